cache_controller: RTL and testbench

Sequencing FSM for the direct-mapped, 4-word-block instruction/data cache of the MIPS core. Sits between the CPU memory stage, the cache data array and main memory. Holds the tag/valid store, decides hit/miss, stalls the pipeline, performs 4-word block refills on read miss, and enforces a write-through, no-write-allocate policy.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_tag_store.sv | 43 ++++
 rtl/cache_controller.sv | 146 ++++++++++++++
 tb/tb_cache_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped, 4-word-block cache controller.
// No logic; elaboration-time constants only.
// Not applicable (no datapath).
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_W        = 2;

    // Index bits needed to select one of 'blocks' cache lines.
    function automatic int idx_w(input int blocks);
        return $clog2(blocks);
    endfunction

    // Tag bits left over once the word offset and index are removed.
    function automatic int tag_w(input int addr_w, input int blocks);
        return addr_w - OFFSET_W - $clog2(blocks);
    endfunction

    // Data-array word address width: {index, offset}.
    function automatic int waddr_w(input int blocks);
        return $clog2(WORDS_PER_BLOCK * blocks);
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag + valid register file, one combinational lookup port and one write port.
// Lookup is 0-cycle; a write is visible from the cycle after it is presented.
// No backpressure: writes are always accepted.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int TAG_W = 27
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             hit_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];

    // Reset invalidates every line; a completed fill marks its line valid with the new tag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            tag_q[wr_idx_i]   <= wr_tag_i;
        end
    end

    // Hit is purely combinational from the stored state.
    always_comb begin
        hit_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped cache sequencer: read-miss 4-word refill, write-through, no write-allocate.
// Read hit 0 cycles; read miss 1 + 4*L stall cycles; write stalls until memory accepts.
// Pipeline held via stall; memory requests are level-held until mem_ready.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCKS_NUM = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cpu_rd,
    input  logic                           cpu_wr,
    input  logic [ADDR_WIDTH-1:0]          cpu_addr,
    input  logic [DATA_WIDTH-1:0]          cpu_wdata,
    output logic                           stall,
    output logic                           hit,
    output logic [waddr_w(BLOCKS_NUM)-1:0] cache_raddr,
    output logic                           cache_we,
    output logic [waddr_w(BLOCKS_NUM)-1:0] cache_waddr,
    output logic [DATA_WIDTH-1:0]          cache_wdata,
    output logic                           mem_rd,
    output logic                           mem_wr,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic                           mem_ready,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int IDX_W = idx_w(BLOCKS_NUM);
    localparam int TAG_W = tag_w(ADDR_WIDTH, BLOCKS_NUM);

    state_e                state_q, state_d;
    logic [OFFSET_W-1:0]   cnt_q, cnt_d;

    logic [OFFSET_W-1:0]   addr_offset;
    logic [IDX_W-1:0]      addr_index;
    logic [TAG_W-1:0]      addr_tag;
    logic [ADDR_WIDTH-1:0] block_base;
    logic                  fill_done;

    assign addr_offset = cpu_addr[OFFSET_W-1:0];
    assign addr_index  = cpu_addr[IDX_W+OFFSET_W-1:OFFSET_W];
    assign addr_tag    = cpu_addr[ADDR_WIDTH-1:IDX_W+OFFSET_W];
    assign block_base  = {cpu_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};

    // The line only becomes valid once the last word has landed, so an aborted fill stays invalid.
    assign fill_done = (state_q == FILL) && mem_ready && (cnt_q == 2'd3);

    cache_tag_store #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_store (
        .clk_i    (clk),
        .rst_i    (rst),
        .rd_idx_i (addr_index),
        .rd_tag_i (addr_tag),
        .hit_o    (hit),
        .wr_en_i  (fill_done),
        .wr_idx_i (addr_index),
        .wr_tag_i (addr_tag)
    );

    // State and fill-counter registers; reset aborts any fill or write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state decode and output muxing; every output idles at zero unless a state drives it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        cache_raddr = '0;
        cache_we    = 1'b0;
        cache_waddr = '0;
        cache_wdata = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            IDLE: begin
                // Stores win over loads when both are presented.
                if (cpu_wr) begin
                    stall   = 1'b1;
                    state_d = WRITE;
                end else if (cpu_rd) begin
                    if (hit) begin
                        cache_raddr = {addr_index, addr_offset};
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = '0;
                        state_d = FILL;
                    end
                end
            end

            FILL: begin
                // Stall stays high through the last word; the request replays as a hit in IDLE.
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = block_base + ADDR_WIDTH'(cnt_q);
                if (mem_ready) begin
                    cache_we    = 1'b1;
                    cache_waddr = {addr_index, cnt_q};
                    cache_wdata = mem_rdata;
                    cnt_d       = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end

            WRITE: begin
                // Write-through: memory always written; the array is only updated on a hit.
                stall     = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (mem_ready) begin
                    stall   = 1'b0;
                    state_d = IDLE;
                    if (hit) begin
                        cache_we    = 1'b1;
                        cache_waddr = {addr_index, addr_offset};
                        cache_wdata = cpu_wdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a latency-programmable memory responder.
// Memory answers after 'lat' cycles of a held request.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        stall;
    logic        hit;
    logic [4:0]  cache_raddr;
    logic        cache_we;
    logic [4:0]  cache_waddr;
    logic [31:0] cache_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_chk  = 0;
    int n_pass = 0;
    int lat    = 1;
    int mcnt   = 0;

    // Per-request observations
    int          stall_cyc, rd_cyc, wr_cyc;
    logic        last_hit;
    logic [4:0]  last_raddr;
    logic [31:0] ma_log[$];
    logic [4:0]  wa_log[$];
    logic [31:0] wd_log[$];
    logic [31:0] mw_log[$];

    localparam logic [31:0] RD_PAT = 32'hA500_0000;

    cache_controller #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BLOCKS_NUM (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .stall       (stall),
        .hit         (hit),
        .cache_raddr (cache_raddr),
        .cache_we    (cache_we),
        .cache_waddr (cache_waddr),
        .cache_wdata (cache_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: ready on the lat-th consecutive cycle of a request, data = pattern ^ address.
    always @(posedge clk) begin
        #1;
        if (mem_ready) mcnt = 0;
        if (mem_rd || mem_wr) begin
            mcnt      = mcnt + 1;
            mem_ready = (mcnt >= lat);
        end else begin
            mcnt      = 0;
            mem_ready = 1'b0;
        end
        mem_rdata = mem_ready ? (RD_PAT ^ mem_addr) : 32'h0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present a request (caller sits at posedge+2) and follow it until stall drops.
    task automatic request(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdat);
        int guard;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdat;
        stall_cyc = 0; rd_cyc = 0; wr_cyc = 0; guard = 0;
        ma_log.delete(); wa_log.delete(); wd_log.delete(); mw_log.delete();
        forever begin
            @(negedge clk);
            if (mem_rd) rd_cyc++;
            if (mem_wr) wr_cyc++;
            if (mem_ready && (mem_rd || mem_wr)) ma_log.push_back(mem_addr);
            if (mem_ready && mem_wr) mw_log.push_back(mem_wdata);
            if (cache_we) begin
                wa_log.push_back(cache_waddr);
                wd_log.push_back(cache_wdata);
            end
            if (!stall) break;
            stall_cyc++;
            guard++;
            if (guard > 100) begin
                chk("stall_timeout", 64'(stall), 64'(0));
                break;
            end
            @(posedge clk); #2;
        end
        last_hit   = hit;
        last_raddr = cache_raddr;
        @(posedge clk); #2;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    initial begin
        // ---- Reset ----
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall",    64'(stall),       64'(0));
        chk("rst_hit",      64'(hit),         64'(0));
        chk("rst_we",       64'(cache_we),    64'(0));
        chk("rst_mem_rd",   64'(mem_rd),      64'(0));
        chk("rst_mem_wr",   64'(mem_wr),      64'(0));
        chk("rst_mem_addr", 64'(mem_addr),    64'(0));
        chk("rst_raddr",    64'(cache_raddr), 64'(0));
        @(posedge clk); #2;

        // ---- Read miss 0x40, latency 1 ----
        lat = 1;
        request(1'b1, 1'b0, 32'h40, 32'h0);
        chk("miss40_stall",  64'(stall_cyc), 64'(5));
        chk("miss40_rdcyc",  64'(rd_cyc),    64'(4));
        chk("miss40_nwords", 64'(ma_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("miss40_maddr%0d", i), 64'(ma_log[i]), 64'(32'h40 + i));
            chk($sformatf("miss40_waddr%0d", i), 64'(wa_log[i]), 64'(i));
            chk($sformatf("miss40_wdata%0d", i), 64'(wd_log[i]), 64'(RD_PAT ^ (32'h40 + i)));
        end
        chk("miss40_hit",   64'(last_hit),   64'(1));
        chk("miss40_raddr", 64'(last_raddr), 64'(0));

        // ---- Read hit 0x42 ----
        request(1'b1, 1'b0, 32'h42, 32'h0);
        chk("hit42_stall", 64'(stall_cyc),  64'(0));
        chk("hit42_rdcyc", 64'(rd_cyc),     64'(0));
        chk("hit42_hit",   64'(last_hit),   64'(1));
        chk("hit42_raddr", 64'(last_raddr), 64'(2));

        // ---- Conflict 0x60 evicts 0x40 block ----
        request(1'b1, 1'b0, 32'h60, 32'h0);
        chk("miss60_stall", 64'(stall_cyc), 64'(5));
        chk("miss60_maddr", 64'(ma_log[0]), 64'(32'h60));
        chk("miss60_waddr", 64'(wa_log[0]), 64'(0));
        chk("miss60_wdata3", 64'(wd_log[3]), 64'(RD_PAT ^ 32'h63));
        request(1'b1, 1'b0, 32'h41, 32'h0);
        chk("miss41_stall", 64'(stall_cyc), 64'(5));
        chk("miss41_maddr", 64'(ma_log[0]), 64'(32'h40));
        chk("miss41_raddr", 64'(last_raddr), 64'(1));

        // ---- Write hit 0x41, latency 3 ----
        lat = 3;
        request(1'b0, 1'b1, 32'h41, 32'hDEAD_BEEF);
        chk("wr41_stall",  64'(stall_cyc),      64'(3));
        chk("wr41_wrcyc",  64'(wr_cyc),         64'(3));
        chk("wr41_maddr",  64'(ma_log[0]),      64'(32'h41));
        chk("wr41_mwdata", 64'(mw_log[0]),      64'(32'hDEAD_BEEF));
        chk("wr41_nwe",    64'(wa_log.size()),  64'(1));
        chk("wr41_waddr",  64'(wa_log[0]),      64'(1));
        chk("wr41_wdata",  64'(wd_log[0]),      64'(32'hDEAD_BEEF));
        chk("wr41_rdcyc",  64'(rd_cyc),         64'(0));

        // ---- Write miss 0x80, latency 2: no allocation ----
        lat = 2;
        request(1'b0, 1'b1, 32'h80, 32'h1234_5678);
        chk("wr80_stall", 64'(stall_cyc),     64'(2));
        chk("wr80_wrcyc", 64'(wr_cyc),        64'(2));
        chk("wr80_maddr", 64'(ma_log[0]),     64'(32'h80));
        chk("wr80_nwe",   64'(wa_log.size()), 64'(0));
        chk("wr80_hit",   64'(last_hit),      64'(0));
        lat = 1;
        request(1'b1, 1'b0, 32'h41, 32'h0);
        chk("hit41_after_wr80", 64'(stall_cyc), 64'(0));
        request(1'b1, 1'b0, 32'h80, 32'h0);
        chk("rd80_stall", 64'(stall_cyc), 64'(5));
        chk("rd80_maddr", 64'(ma_log[0]), 64'(32'h80));

        // ---- Reset in the middle of a fill of 0x40 ----
        cpu_rd = 1'b1; cpu_addr = 32'h40;
        @(posedge clk); #2;           // first fill word
        @(posedge clk); #2;           // second fill word
        @(negedge clk);
        chk("abort_we_w1",    64'(cache_we),    64'(1));
        chk("abort_waddr_w1", 64'(cache_waddr), 64'(1));
        #1 rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        chk("abort_mem_rd", 64'(mem_rd),   64'(0));
        chk("abort_we",     64'(cache_we), 64'(0));
        chk("abort_stall",  64'(stall),    64'(0));
        cpu_addr = 32'h80;
        #1 chk("abort_valid_clr", 64'(hit), 64'(0));
        @(posedge clk); #2;
        request(1'b1, 1'b0, 32'h40, 32'h0);
        chk("refetch_stall",  64'(stall_cyc),     64'(5));
        chk("refetch_nwords", 64'(ma_log.size()), 64'(4));
        chk("refetch_maddr0", 64'(ma_log[0]),     64'(32'h40));

        // ---- Read and write together: write wins ----
        request(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
        chk("rdwr_stall", 64'(stall_cyc),  64'(1));
        chk("rdwr_rdcyc", 64'(rd_cyc),     64'(0));
        chk("rdwr_wrcyc", 64'(wr_cyc),     64'(1));
        chk("rdwr_waddr", 64'(wa_log[0]),  64'(0));
        chk("rdwr_wdata", 64'(wd_log[0]),  64'(32'hCAFE_F00D));

        // ---- Idle: stray mem_ready-free quiet cycle ----
        @(negedge clk);
        chk("idle_stall", 64'(stall),  64'(0));
        chk("idle_memwr", 64'(mem_wr), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
